// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, frame-aligned
// shadow loading, anti-ghost guard blanking and optional leading-zero suppression.
module seg_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned LZ_SUPPRESS  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic                      load,
  output logic                      load_ack,
  output logic [NUM_DIGITS-1:0]     digit_select,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int unsigned TICKS_RAW = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned TICKS     = (TICKS_RAW == 0) ? 1 : TICKS_RAW;
  localparam int unsigned CW        = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int unsigned IW        = $clog2(NUM_DIGITS);
  localparam int unsigned VW        = 4 * NUM_DIGITS;

  logic [CW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic                  r_pending;
  logic [VW-1:0]         r_sh_value;
  logic [NUM_DIGITS-1:0] r_sh_dp;
  logic [NUM_DIGITS-1:0] r_sh_blank;

  logic                  w_tc;
  logic                  w_wrap;
  logic                  w_capture;
  logic                  w_guard;
  logic                  w_off;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [NUM_DIGITS-1:0] w_keep;
  logic                  w_any_nz;

  assign w_tc      = (r_presc == CW'(TICKS - 1));
  assign w_wrap    = w_tc && (r_idx == IW'(NUM_DIGITS - 1));
  // A load arriving in the wrap cycle itself is captured at that boundary.
  assign w_capture = w_wrap && (r_pending || load);

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (32'(r_presc) < GUARD_CYCLES);
    end
  endgenerate

  // Digit k survives suppression if any nibble at or above k is nonzero.
  always_comb begin
    w_keep   = '0;
    w_any_nz = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      w_any_nz  = w_any_nz | (r_sh_value[4*k +: 4] != 4'h0);
      w_keep[k] = w_any_nz | (k == 0) | r_sh_dp[k] | (LZ_SUPPRESS == 0);
    end
  end

  assign w_nib = 4'(r_sh_value >> {r_idx, 2'b00});
  assign w_sel = ~(NUM_DIGITS'(1) << r_idx);
  assign w_off = w_guard | r_sh_blank[r_idx] | ~w_keep[r_idx];

  // Active-low {g,f,e,d,c,b,a} hex font.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_sh_value   <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      load_ack     <= 1'b0;
      frame_done   <= 1'b0;
      digit_select <= '1;
      seg          <= 7'b1111111;
      dp           <= 1'b1;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + CW'(1);
      if (w_tc) begin
        r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end
      r_pending <= (r_pending | load) & ~w_capture;
      if (w_capture) begin
        r_sh_value <= value;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_mask;
      end
      load_ack     <= w_capture;
      frame_done   <= w_wrap;
      digit_select <= w_off ? '1 : w_sel;
      seg          <= w_off ? 7'b1111111 : w_seg;
      dp           <= w_off ? 1'b1 : ~r_sh_dp[r_idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: one instance without and one with
// leading-zero suppression, driven from the same stimulus.
module tb_seg_scan_controller;

  localparam int N  = 8;
  localparam int GD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_mask = '0;
  logic        load = 1'b0;

  logic       ack_a, fd_a, dp_a, ack_b, fd_b, dp_b;
  logic [7:0] sel_a, sel_b;
  logic [6:0] seg_a, seg_b;

  int total = 0;
  int bad   = 0;
  int ph    = 0;

  always #5 clk = ~clk;

  seg_scan_controller #(.NUM_DIGITS(N), .CLK_HZ(800), .REFRESH_HZ(10),
                        .GUARD_CYCLES(GD), .LZ_SUPPRESS(0)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .load(load), .load_ack(ack_a),
    .digit_select(sel_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a));

  seg_scan_controller #(.NUM_DIGITS(N), .CLK_HZ(800), .REFRESH_HZ(10),
                        .GUARD_CYCLES(GD), .LZ_SUPPRESS(1)) dut_lz (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .load(load), .load_ack(ack_b),
    .digit_select(sel_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b));

  // ph = scan count the pins currently reflect (one-cycle pin latency).
  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected {digit_select, seg, dp}; mask = digits that should be lit.
  function automatic logic [15:0] exp_pins(input logic [31:0] v, input logic [7:0] dpv,
                                           input logic [7:0] mask, input int p);
    int idx;
    int pre;
    idx = (p / 10) % 8;
    pre = p % 10;
    if (pre < GD || !mask[idx]) return {8'hFF, 7'h7F, 1'b1};
    return {~(8'h01 << idx), seg_of(v[4*idx +: 4]), ~dpv[idx]};
  endfunction

  task automatic test_reset();
    reset = 1'b0; value = 32'hFFFFFFFF; dp_in = 8'hFF; load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sel_a, seg_a, dp_a} !== {8'hFF, 7'h7F, 1'b1}) begin
      bad++; $display("FAIL reset_pins got=%h exp=%h", {sel_a, seg_a, dp_a}, {8'hFF, 7'h7F, 1'b1});
    end
    total++;
    if ({ack_a, fd_a, ack_b, fd_b} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses got=%b exp=0000", {ack_a, fd_a, ack_b, fd_b});
    end
    load = 1'b0; value = '0; dp_in = '0; blank_mask = '0;
    reset = 1'b1;
    ph = -1;
  endtask

  task automatic test_scan();
    logic [15:0] ea, eb;
    logic        ef;
    for (int c = 0; c < 160; c++) begin
      tick();
      ea = exp_pins(32'h0, 8'h00, 8'hFF, ph);
      eb = exp_pins(32'h0, 8'h00, 8'h01, ph);
      ef = (ph % 80 == 79);
      total++;
      if ({sel_a, seg_a, dp_a} !== ea) begin
        bad++; $display("FAIL scan_pins ph=%0d got=%h exp=%h", ph, {sel_a, seg_a, dp_a}, ea);
      end
      total++;
      if ({sel_b, seg_b, dp_b} !== eb) begin
        bad++; $display("FAIL scan_lz_zero ph=%0d got=%h exp=%h", ph, {sel_b, seg_b, dp_b}, eb);
      end
      total++;
      if ({ack_a, fd_a, ack_b, fd_b} !== {1'b0, ef, 1'b0, ef}) begin
        bad++; $display("FAIL scan_frame_done ph=%0d got=%b exp=%b", ph, {ack_a, fd_a, ack_b, fd_b}, {1'b0, ef, 1'b0, ef});
      end
    end
  endtask

  task automatic test_decode_timing();
    logic [15:0] ea, eb;
    logic        ef, ek;
    value = 32'h76543210; dp_in = 8'h01; blank_mask = 8'h00;
    for (int c = 0; c < 160; c++) begin
      tick();
      ea = (c < 80) ? exp_pins(32'h0, 8'h00, 8'hFF, ph) : exp_pins(32'h76543210, 8'h01, 8'hFF, ph);
      eb = (c < 80) ? exp_pins(32'h0, 8'h00, 8'h01, ph) : exp_pins(32'h76543210, 8'h01, 8'hFF, ph);
      ef = (c % 80 == 79);
      ek = (c == 79);
      total++;
      if ({sel_a, seg_a, dp_a} !== ea) begin
        bad++; $display("FAIL decode_pins c=%0d got=%h exp=%h", c, {sel_a, seg_a, dp_a}, ea);
      end
      total++;
      if ({sel_b, seg_b, dp_b} !== eb) begin
        bad++; $display("FAIL decode_lz_pins c=%0d got=%h exp=%h", c, {sel_b, seg_b, dp_b}, eb);
      end
      total++;
      if ({ack_a, fd_a, ack_b, fd_b} !== {ek, ef, ek, ef}) begin
        bad++; $display("FAIL decode_ack c=%0d got=%b exp=%b", c, {ack_a, fd_a, ack_b, fd_b}, {ek, ef, ek, ef});
      end
      if (c == 29) load = 1'b1;
      if (c == 30) load = 1'b0;
    end
  endtask

  task automatic test_load_held();
    logic [15:0] ea;
    logic        ef, ek;
    value = 32'hFEDCBA98; dp_in = 8'h80; load = 1'b1;
    for (int c = 0; c < 240; c++) begin
      tick();
      ea = (c < 80) ? exp_pins(32'h76543210, 8'h01, 8'hFF, ph) : exp_pins(32'hFEDCBA98, 8'h80, 8'hFF, ph);
      ef = (c % 80 == 79);
      ek = (c == 79) || (c == 159);
      total++;
      if ({sel_a, seg_a, dp_a} !== ea || {sel_b, seg_b, dp_b} !== ea) begin
        bad++; $display("FAIL held_pins c=%0d got=%h/%h exp=%h", c, {sel_a, seg_a, dp_a}, {sel_b, seg_b, dp_b}, ea);
      end
      total++;
      if ({ack_a, fd_a, ack_b, fd_b} !== {ek, ef, ek, ef}) begin
        bad++; $display("FAIL held_ack c=%0d got=%b exp=%b", c, {ack_a, fd_a, ack_b, fd_b}, {ek, ef, ek, ef});
      end
      if (c == 99) load = 1'b0;
    end
  endtask

  task automatic test_boundary_lz();
    logic [15:0] ea, eb;
    logic        ef, ek;
    value = 32'h00000305; dp_in = 8'h00; blank_mask = 8'h00;
    for (int c = 0; c < 160; c++) begin
      tick();
      ea = (c < 80) ? exp_pins(32'hFEDCBA98, 8'h80, 8'hFF, ph) : exp_pins(32'h00000305, 8'h00, 8'hFF, ph);
      eb = (c < 80) ? exp_pins(32'hFEDCBA98, 8'h80, 8'hFF, ph) : exp_pins(32'h00000305, 8'h00, 8'h07, ph);
      ef = (c % 80 == 79);
      ek = (c == 79);
      total++;
      if ({sel_a, seg_a, dp_a} !== ea) begin
        bad++; $display("FAIL boundary_pins c=%0d got=%h exp=%h", c, {sel_a, seg_a, dp_a}, ea);
      end
      total++;
      if ({sel_b, seg_b, dp_b} !== eb) begin
        bad++; $display("FAIL lz_305_pins c=%0d got=%h exp=%h", c, {sel_b, seg_b, dp_b}, eb);
      end
      total++;
      if ({ack_a, fd_a, ack_b, fd_b} !== {ek, ef, ek, ef}) begin
        bad++; $display("FAIL boundary_ack c=%0d got=%b exp=%b", c, {ack_a, fd_a, ack_b, fd_b}, {ek, ef, ek, ef});
      end
      if (c == 78) load = 1'b1;
      if (c == 79) load = 1'b0;
    end
  endtask

  task automatic test_blank();
    logic [15:0] ea, eb;
    logic        ef, ek;
    value = 32'h0; dp_in = 8'h10; blank_mask = 8'h80;
    for (int c = 0; c < 160; c++) begin
      tick();
      ea = (c < 80) ? exp_pins(32'h305, 8'h00, 8'hFF, ph) : exp_pins(32'h0, 8'h10, 8'h7F, ph);
      eb = (c < 80) ? exp_pins(32'h305, 8'h00, 8'h07, ph) : exp_pins(32'h0, 8'h10, 8'h11, ph);
      ef = (c % 80 == 79);
      ek = (c == 79);
      total++;
      if ({sel_a, seg_a, dp_a} !== ea) begin
        bad++; $display("FAIL blank_pins c=%0d got=%h exp=%h", c, {sel_a, seg_a, dp_a}, ea);
      end
      total++;
      if ({sel_b, seg_b, dp_b} !== eb) begin
        bad++; $display("FAIL lz_dp_pins c=%0d got=%h exp=%h", c, {sel_b, seg_b, dp_b}, eb);
      end
      total++;
      if ({ack_a, fd_a, ack_b, fd_b} !== {ek, ef, ek, ef}) begin
        bad++; $display("FAIL blank_ack c=%0d got=%b exp=%b", c, {ack_a, fd_a, ack_b, fd_b}, {ek, ef, ek, ef});
      end
      if (c == 10) load = 1'b1;
      if (c == 11) load = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ea, eb;
    logic        ef;
    value = 32'h11111111; dp_in = 8'hFF; blank_mask = 8'h00;
    for (int c = 0; c < 45; c++) begin
      tick();
      ea = exp_pins(32'h0, 8'h10, 8'h7F, ph);
      total++;
      if ({sel_a, seg_a, dp_a} !== ea || {ack_a, fd_a} !== 2'b00) begin
        bad++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, {sel_a, seg_a, dp_a, ack_a, fd_a}, {ea, 2'b00});
      end
      if (c == 30) load = 1'b1;
      if (c == 31) load = 1'b0;
    end
    reset = 1'b0;
    #1;
    total++;
    if ({sel_a, seg_a, dp_a, ack_a, fd_a} !== {8'hFF, 7'h7F, 1'b1, 2'b00}) begin
      bad++; $display("FAIL reset_async got=%h exp=%h", {sel_a, seg_a, dp_a, ack_a, fd_a}, {8'hFF, 7'h7F, 1'b1, 2'b00});
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({sel_b, seg_b, dp_b, ack_b, fd_b} !== {8'hFF, 7'h7F, 1'b1, 2'b00}) begin
      bad++; $display("FAIL reset_held got=%h exp=%h", {sel_b, seg_b, dp_b, ack_b, fd_b}, {8'hFF, 7'h7F, 1'b1, 2'b00});
    end
    reset = 1'b1;
    ph = -1;
    for (int c = 0; c < 160; c++) begin
      tick();
      ea = exp_pins(32'h0, 8'h00, 8'hFF, ph);
      eb = exp_pins(32'h0, 8'h00, 8'h01, ph);
      ef = (ph % 80 == 79);
      total++;
      if ({sel_a, seg_a, dp_a} !== ea || {sel_b, seg_b, dp_b} !== eb) begin
        bad++; $display("FAIL restart_pins ph=%0d got=%h/%h exp=%h/%h", ph, {sel_a, seg_a, dp_a}, {sel_b, seg_b, dp_b}, ea, eb);
      end
      total++;
      if ({ack_a, fd_a, ack_b, fd_b} !== {1'b0, ef, 1'b0, ef}) begin
        bad++; $display("FAIL restart_ack ph=%0d got=%b exp=%b", ph, {ack_a, fd_a, ack_b, fd_b}, {1'b0, ef, 1'b0, ef});
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode_timing();
    test_load_held();
    test_boundary_lz();
    test_blank();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
